assoc_cache_controller: RTL
===========================

// Module: assoc_cache_controller
// PURPOSE
// 2-way set-associative, write-allocate cache controller with integrated line-fill FSM and per-set LRU.
// Parametrised successor of the direct-mapped controller; one instance each for I-cache and D-cache.
// Sits between the pipeline (op/write/address_in) and the memory arbitrator (service/data_valid).
// Holds data, tag, valid and LRU arrays internally; write-through to memory is handled by the arbitrator.
// PARAMETERS
// ADDR_W    16  byte address width; bit 0 unused (word aligned)
// DATA_W    16  word width
// INDEX_W   6   set index bits; SETS = 2**INDEX_W
// OFFSET_W  3   word-in-block bits; WORDS = 2**OFFSET_W
// TAG_W = ADDR_W-INDEX_W-OFFSET_W-1 (derived). Address fields: tag=[ADDR_W-1:INDEX_W+OFFSET_W+1],
// index=[INDEX_W+OFFSET_W:OFFSET_W+1], offset=[OFFSET_W:1].
// PORTS
// clk            in   1       clock, all state on rising edge
// rst            in   1       synchronous reset, active-high
// op             in   1       access request this cycle
// write          in   1       access is a store (with op)
// address_in     in   ADDR_W  access byte address
// data_in        in   DATA_W  store data
// data_out       out  DATA_W  load data (combinational, valid when op & hit)
// hit            out  1       op & tag match on a valid way & ~fsm_busy
// stall          out  1       op & ~hit, or fsm_busy
// service        in   1       arbitrator grant; address issued when high
// data_valid     in   1       fill word returning from memory
// data_from_mem  in   DATA_W  fill word
// addr_to_mem    out  ADDR_W  fsm_busy ? fill address : address_in
// fsm_busy       out  1       fill in progress (state != IDLE)
// BEHAVIOUR
// - Reset: state IDLE, all valid=0, all LRU=0, issue_cnt=rx_cnt=0; outputs hit=0, stall=op, fsm_busy=0.
// - Hit: compare tag against both ways of set; data_out muxes hitting way. Store hit writes data_in into
//   that way/word at clock edge. Every hit (load or store) sets LRU[set] = other way.
// - Victim: way0 if invalid, else way1 if invalid, else LRU[set].
// - FSM IDLE: op & miss -> latch block base (offset cleared), set, tag, victim; clear victim valid; -> FILL.
// - FILL: while service & issue_cnt<WORDS, addr_to_mem = base + 2*issue_cnt, issue_cnt++. Each data_valid
//   writes data_from_mem to victim word rx_cnt, rx_cnt++. data_valid with rx_cnt=WORDS-1 -> DONE.
//   data_valid accepted even if service low (memory latency pipeline).
// - DONE (1 cycle): write latched tag, valid=1, LRU[set]=other way; counters cleared -> IDLE.
// - Pending access replays in IDLE and hits; store after write-miss completes then (1 extra cycle).
// - During FILL/DONE: address_in changes ignored (latched), store writes suppressed, data_out don't-care.
// - Victim valid cleared at fill start: partial line never hits.
// - Simultaneous issue of last address and data_valid of an earlier word: both handled same cycle.
// - rst mid-fill: abort to IDLE, all lines invalid; late data_valid in IDLE ignored.
// - op=0: no miss, no LRU update, stall=fsm_busy.
// CONFIGURATION
// CACHE_STATS_EN defined: adds outputs hit_count[15:0], miss_count[15:0]; hit_count++ per hit cycle,
//   miss_count++ per IDLE->FILL transition; both saturate at 0xFFFF, cleared by rst.
// CACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING (defaults; 0x1234 -> tag 0x04, index 0x23, offset 2)
// 1 Cold load 0x1234, memory returns 0xA000+word, 4-cycle latency -> stall until DONE, addr_to_mem
//   0x1230..0x123E, then hit=1, data_out=0xA002; victim way0.
// 2 Load 0x5234 (tag 0x14, same set) -> fills way1; reload 0x1234 and 0x5234 both hit, no stall.
// 3 Touch 0x1234 then load 0x9234 -> evicts way1 (LRU); 0x5234 then misses, 0x1234 still hits.
// 4 Store 0x1236 data 0xBEEF on hit -> next load 0x1236 = 0xBEEF, no stall; store miss 0xD000 -> fill,
//   then 0xD000 reads store data, other words memory data.
// 5 service toggled 1,0,1 during fill -> addresses issued only on service cycles, all 8 words land in order.
// 6 rst asserted at rx_cnt=3 -> fsm_busy=0 next cycle, 0x1234 misses; CACHE_STATS_EN: counts 0 after rst.

Source files
------------

// File: rtl/assoc_cache_controller.sv
// 2-way set-associative write-allocate cache controller with line-fill FSM and per-set LRU.
// Optional hit/miss statistics outputs are compiled in when CACHE_STATS_EN is defined.
module assoc_cache_controller #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op,
  input  logic              write,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              hit,
  output logic              stall,
  input  logic              service,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_from_mem,
  output logic [ADDR_W-1:0] addr_to_mem,
  output logic              fsm_busy
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 1;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam logic [OFFSET_W:0] ALL_WORDS = (OFFSET_W+1)'(WORDS);
  localparam logic [OFFSET_W:0] LAST_WORD = (OFFSET_W+1)'(WORDS - 1);
  localparam logic [OFFSET_W:0] CNT_ONE   = (OFFSET_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]    data_q [2][SETS][WORDS];
  logic [TAG_W-1:0]     tag_q  [2][SETS];
  logic [1:0][SETS-1:0] valid_q;
  logic [SETS-1:0]      lru_q;

  logic [OFFSET_W:0]  issue_q, issue_d;
  logic [OFFSET_W:0]  rx_q, rx_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [INDEX_W-1:0] fidx_q, fidx_d;
  logic [TAG_W-1:0]   ftag_q, ftag_d;
  logic               fway_q, fway_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                match0, match1, any_match, hit_way, victim;
  logic                busy, miss_start, fill_wr, store_hit;
  logic                unused_addr_lsb;

  assign req_tag         = address_in[ADDR_W-1 -: TAG_W];
  assign req_idx         = address_in[OFFSET_W+1 +: INDEX_W];
  assign req_off         = address_in[1 +: OFFSET_W];
  assign unused_addr_lsb = address_in[0];

  always_comb begin
    match0     = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    match1     = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    any_match  = match0 || match1;
    hit_way    = match1;
    busy       = (state_q != S_IDLE);
    hit        = op && any_match && !busy;
    stall      = (op && !hit) || busy;
    miss_start = op && !any_match && !busy;
    store_hit  = hit && write;
    fill_wr    = (state_q == S_FILL) && data_valid;
    data_out   = data_q[hit_way][req_idx][req_off];
    fsm_busy   = busy;
    // Fill addresses are only meaningful while busy; otherwise the request passes straight through.
    addr_to_mem = busy ? (base_q + ADDR_W'({issue_q, 1'b0})) : address_in;
    if (!valid_q[0][req_idx])      victim = 1'b0;
    else if (!valid_q[1][req_idx]) victim = 1'b1;
    else                           victim = lru_q[req_idx];
  end

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    rx_d    = rx_q;
    base_d  = base_q;
    fidx_d  = fidx_q;
    ftag_d  = ftag_q;
    fway_d  = fway_q;
    case (state_q)
      S_IDLE: begin
        if (miss_start) begin
          base_d  = {address_in[ADDR_W-1:OFFSET_W+1], {(OFFSET_W+1){1'b0}}};
          fidx_d  = req_idx;
          ftag_d  = req_tag;
          fway_d  = victim;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // Issue and return are independent: memory may still be returning earlier words.
        if (service && (issue_q < ALL_WORDS)) issue_d = issue_q + CNT_ONE;
        if (data_valid) begin
          rx_d = rx_q + CNT_ONE;
          if (rx_q == LAST_WORD) state_d = S_DONE;
        end
      end
      S_DONE: begin
        issue_d = '0;
        rx_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      issue_q <= '0;
      rx_q    <= '0;
      base_q  <= '0;
      fidx_q  <= '0;
      ftag_q  <= '0;
      fway_q  <= 1'b0;
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      rx_q    <= rx_d;
      base_q  <= base_d;
      fidx_q  <= fidx_d;
      ftag_q  <= ftag_d;
      fway_q  <= fway_d;
      // Invalidate the victim up front so a partially filled line can never hit.
      if (miss_start) valid_q[victim][req_idx] <= 1'b0;
      if (state_q == S_DONE) begin
        valid_q[fway_q][fidx_q] <= 1'b1;
        lru_q[fidx_q]           <= ~fway_q;
      end
      if (hit) lru_q[req_idx] <= ~hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if (store_hit) data_q[hit_way][req_idx][req_off] <= data_in;
    if (fill_wr)   data_q[fway_q][fidx_q][rx_q[OFFSET_W-1:0]] <= data_from_mem;
    if (state_q == S_DONE) tag_q[fway_q][fidx_q] <= ftag_q;
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != 16'hFFFF))         hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (miss_start && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
